// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-SRAM arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_CPU  = 2'd1,
      ARB_EXT  = 2'd2
   } arb_owner_e;

   localparam int unsigned DMEM_ADDR_W    = 10;
   localparam int unsigned DMEM_DATA_W    = 32;
   localparam int unsigned DMEM_MAX_BURST = 16;

endpackage

// File: rtl/dmem_arb_burst_cnt.sv
// Saturating count of locked external grants taken while the CPU is waiting.
module dmem_arb_burst_cnt
   import dmem_arb_pkg::*;
#(
   parameter int unsigned MAX_BURST = DMEM_MAX_BURST
) (
   input  logic clk,
   input  logic arst_n,
   input  logic clr,
   input  logic inc,
   output logic at_max
);

   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != CNT_MAX)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign at_max = (cnt == CNT_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-SRAM arbiter between the CPU memory stage and the external port.
// Define DMEM_ARB_RR_EN for round-robin on contested cycles; default is CPU priority.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W    = DMEM_ADDR_W,
   parameter int unsigned DATA_W    = DMEM_DATA_W,
   parameter int unsigned MAX_BURST = DMEM_MAX_BURST
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              cpu_req,
   input  logic              cpu_wen,
   input  logic [31:0]       cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ext_req,
   input  logic              ext_wen,
   input  logic              ext_lock,
   input  logic [31:0]       ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_gnt,
   output logic              ext_rvalid,
   output logic [DATA_W-1:0] ext_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic              mem_ren,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_owner_e        state;
   arb_owner_e        next_state;
   arb_owner_e        rd_own;
   logic              rd_pend;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] ext_rdata_q;
   logic              at_max;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                               ext_addr[31:ADDR_W+2], ext_addr[1:0]};

   dmem_arb_burst_cnt #(
      .MAX_BURST (MAX_BURST)
   ) u_burst_cnt (
      .clk    (clk),
      .arst_n (arst_n),
      .clr    (cpu_gnt || !cpu_req),
      .inc    (ext_gnt && cpu_req),
      .at_max (at_max)
   );

   // Grants are held off while reset is asserted so no strobe leaks out.
   always_comb begin
      cpu_gnt = 1'b0;
      ext_gnt = 1'b0;
      if (arst_n) begin
         if (cpu_req && ext_req) begin
            if ((state == ARB_EXT) && ext_lock && !at_max) begin
               ext_gnt = 1'b1;
`ifdef DMEM_ARB_RR_EN
            end else if (state == ARB_CPU) begin
               ext_gnt = 1'b1;
`endif
            end else begin
               cpu_gnt = 1'b1;
            end
         end else begin
            cpu_gnt = cpu_req;
            ext_gnt = ext_req;
         end
      end
   end

   assign cpu_stall = cpu_req && !cpu_gnt;

   always_comb begin
      next_state = ARB_IDLE;
      if (cpu_gnt) begin
         next_state = ARB_CPU;
      end else if (ext_gnt) begin
         next_state = ARB_EXT;
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_wen   = 1'b0;
      mem_ren   = 1'b0;
      mem_wdata = '0;
      if (cpu_gnt) begin
         mem_addr  = cpu_addr[ADDR_W+1:2];
         mem_wen   = cpu_wen;
         mem_ren   = !cpu_wen;
         mem_wdata = cpu_wdata;
      end else if (ext_gnt) begin
         mem_addr  = ext_addr[ADDR_W+1:2];
         mem_wen   = ext_wen;
         mem_ren   = !ext_wen;
         mem_wdata = ext_wdata;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state       <= ARB_IDLE;
         rd_pend     <= 1'b0;
         rd_own      <= ARB_IDLE;
         cpu_rdata_q <= '0;
         ext_rdata_q <= '0;
      end else begin
         state   <= next_state;
         rd_pend <= mem_ren;
         rd_own  <= next_state;
         if (cpu_rvalid) begin
            cpu_rdata_q <= mem_rdata;
         end
         if (ext_rvalid) begin
            ext_rdata_q <= mem_rdata;
         end
      end
   end

   // SRAM data arrives the cycle after the strobe, so the return path is a
   // bypass of mem_rdata with a holding register for the idle cycles.
   assign cpu_rvalid = rd_pend && (rd_own == ARB_CPU);
   assign ext_rvalid = rd_pend && (rd_own == ARB_EXT);
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
   assign ext_rdata  = ext_rvalid ? mem_rdata : ext_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter; contested-cycle expectations follow DMEM_ARB_RR_EN.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 32;
   localparam int unsigned MB = 16;

   logic          clk = 1'b0;
   logic          arst_n;
   logic          cpu_req, cpu_wen, cpu_gnt, cpu_stall, cpu_rvalid;
   logic [31:0]   cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          ext_req, ext_wen, ext_lock, ext_gnt, ext_rvalid;
   logic [31:0]   ext_addr;
   logic [DW-1:0] ext_wdata, ext_rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_wen, mem_ren;
   logic [DW-1:0] mem_wdata, mem_rdata;

   logic [DW-1:0]   sram [0:(1<<AW)-1];
   logic [(1<<AW)-1:0] sram_wr = '0;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned stalls;
   logic        ec, pc;

   dmem_arbiter #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .MAX_BURST (MB)
   ) dut (
      .clk        (clk),
      .arst_n     (arst_n),
      .cpu_req    (cpu_req),
      .cpu_wen    (cpu_wen),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_stall  (cpu_stall),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .ext_req    (ext_req),
      .ext_wen    (ext_wen),
      .ext_lock   (ext_lock),
      .ext_addr   (ext_addr),
      .ext_wdata  (ext_wdata),
      .ext_gnt    (ext_gnt),
      .ext_rvalid (ext_rvalid),
      .ext_rdata  (ext_rdata),
      .mem_addr   (mem_addr),
      .mem_wen    (mem_wen),
      .mem_ren    (mem_ren),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input logic [AW-1:0] a);
      return 32'hA5A5_0000 | {22'd0, a};
   endfunction

   // Single-port SRAM model; unwritten words read back as pat(address).
   always @(posedge clk) begin
      if (mem_wen) begin
         sram[mem_addr]    <= mem_wdata;
         sram_wr[mem_addr] <= 1'b1;
      end
      if (mem_ren) begin
         mem_rdata <= sram_wr[mem_addr] ? sram[mem_addr] : pat(mem_addr);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      arst_n = 1'b0;
      cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h100; cpu_wdata = '0;
      ext_req = 1'b1; ext_wen = 1'b0; ext_lock = 1'b0; ext_addr = 32'h104; ext_wdata = '0;
      tick(); tick(); #2;
      chk("rst_cpu_gnt", cpu_gnt, 0);
      chk("rst_ext_gnt", ext_gnt, 0);
      chk("rst_cpu_rvalid", cpu_rvalid, 0);
      chk("rst_ext_rvalid", ext_rvalid, 0);
      chk("rst_mem_wen", mem_wen, 0);
      chk("rst_mem_ren", mem_ren, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_state", 32'(dut.state), 32'(ARB_IDLE));

      arst_n = 1'b1; #1;
      chk("first_cpu_gnt", cpu_gnt, 1);
      chk("first_ext_gnt", ext_gnt, 0);
      chk("first_stall", cpu_stall, 0);
      chk("first_addr", mem_addr, 32'h040);
      chk("first_ren", mem_ren, 1);

      tick(); cpu_req = 1'b0; ext_req = 1'b0; #2;
      chk("first_rvalid", cpu_rvalid, 1);
      chk("first_rdata", cpu_rdata, pat(10'h040));
      chk("first_ext_rvalid", ext_rvalid, 0);
      chk("idle_ren", mem_ren, 0);

      // CPU write then read of byte address 0x40
      tick(); cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hDEADBEEF; #2;
      chk("wr_gnt", cpu_gnt, 1);
      chk("wr_addr", mem_addr, 32'h010);
      chk("wr_wen", mem_wen, 1);
      chk("wr_ren", mem_ren, 0);
      chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
      tick(); cpu_wen = 1'b0; #2;
      chk("rd_addr", mem_addr, 32'h010);
      chk("rd_ren", mem_ren, 1);
      chk("rd_no_rvalid_after_wr", cpu_rvalid, 0);
      tick(); cpu_req = 1'b0; #2;
      chk("rd_rvalid", cpu_rvalid, 1);
      chk("rd_rdata", cpu_rdata, 32'hDEADBEEF);
      chk("idle_addr", mem_addr, 0);
      chk("idle_wen", mem_wen, 0);
      tick(); #2;
      chk("rd_rvalid_drop", cpu_rvalid, 0);
      chk("rd_rdata_hold", cpu_rdata, 32'hDEADBEEF);

      // upper address bits ignored
      tick(); cpu_req = 1'b1; cpu_addr = 32'hFFFF_F010; #2;
      chk("wrap_addr", mem_addr, 32'h004);
      tick(); cpu_req = 1'b0; #2;
      chk("wrap_rdata", cpu_rdata, pat(10'h004));

      // both requesting reads continuously
      cpu_addr = 32'h8; ext_addr = 32'hC;
      for (int k = 0; k < 6; k++) begin
         tick(); cpu_req = 1'b1; ext_req = 1'b1; #2;
`ifdef DMEM_ARB_RR_EN
         ec = (k % 2 == 0);
         pc = ((k - 1) % 2 == 0);
`else
         ec = 1'b1;
         pc = 1'b1;
`endif
         chk("ct_cpu_gnt", cpu_gnt, ec);
         chk("ct_ext_gnt", ext_gnt, !ec);
         chk("ct_stall", cpu_stall, !ec);
         chk("ct_addr", mem_addr, ec ? 32'h2 : 32'h3);
         if (k > 0) begin
            chk("ct_cpu_rvalid", cpu_rvalid, pc);
            chk("ct_ext_rvalid", ext_rvalid, !pc);
            chk("ct_rdata", pc ? cpu_rdata : ext_rdata, pc ? pat(10'h2) : pat(10'h3));
         end
      end
      tick(); cpu_req = 1'b0; ext_req = 1'b0; #2;
`ifdef DMEM_ARB_RR_EN
      chk("ct_last_ext_rvalid", ext_rvalid, 1);
      chk("ct_last_ext_rdata", ext_rdata, pat(10'h3));
`else
      chk("ct_last_cpu_rvalid", cpu_rvalid, 1);
      chk("ct_ext_rdata_hold", ext_rdata, 0);
`endif

      // locked external burst against a waiting CPU
      tick(); ext_req = 1'b1; ext_lock = 1'b1; ext_addr = 32'h1008; #2;
      chk("lk_first_gnt", ext_gnt, 1);
      chk("lk_addr", mem_addr, 32'h002);
      stalls = 0;
      for (int i = 0; i < 17; i++) begin
         tick(); cpu_req = 1'b1; #2;
         chk("lk_ext_gnt", ext_gnt, (i < 16));
         chk("lk_cpu_gnt", cpu_gnt, (i == 16));
         chk("lk_ext_rvalid", ext_rvalid, 1);
         chk("lk_ext_rdata", ext_rdata, pat(10'h002));
         if (cpu_stall) stalls++;
      end
      chk("lk_stall_cycles", stalls, 16);
      tick(); cpu_req = 1'b0; ext_req = 1'b0; ext_lock = 1'b0; #2;
      chk("lk_cpu_rvalid", cpu_rvalid, 1);
      chk("lk_cpu_rdata", cpu_rdata, pat(10'h002));
      chk("lk_ext_rvalid_end", ext_rvalid, 0);

      // reset pulse between an ext read grant and its return
      tick(); ext_req = 1'b1; ext_addr = 32'h20; #1;
      chk("mr_ext_gnt", ext_gnt, 1);
      chk("mr_ren", mem_ren, 1);
      arst_n = 1'b0; #1;
      chk("mr_gnt_in_rst", ext_gnt, 0);
      ext_req = 1'b0; #1;
      arst_n = 1'b1;
      tick(); #2;
      chk("mr_ext_rvalid", ext_rvalid, 0);
      chk("mr_cpu_rvalid", cpu_rvalid, 0);
      chk("mr_state", 32'(dut.state), 32'(ARB_IDLE));
      chk("mr_ext_rdata", ext_rdata, 0);
      tick(); #2;
      chk("mr_ext_rvalid_late", ext_rvalid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
